// File: rtl/tx_input_buffer_v2.sv
// Tx input buffer: AXI4-Lite word writes into a FIFO, drained as AXI4-Stream packets.
// Define TXBUF_IRQ_EN to add the THRESH register (word 4) and the level-threshold irq.
module tx_input_buffer_v2 #(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_S_AXI_ADDR_WIDTH   = 5,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int PKT_LEN_W            = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  output logic                              irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = C_M_AXIS_TDATA_WIDTH;

  logic [TW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        count;
  logic                 push_d1;
  logic                 en, ovf;
  logic [PKT_LEN_W-1:0] pkt_len, cur_len, cnt, len_eff;
  logic [2:0]           wsel, rsel;
  logic                 wr_fire, rd_fire, push, flush;
  logic                 full, empty, avail, load, last;
  logic                 push_ok, ovf_set;
  logic [31:0]          rd_word;

  assign wsel    = S_AXI_AWADDR[4:2];
  assign rsel    = S_AXI_ARADDR[4:2];
  assign wr_fire = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = S_AXI_ARREADY & S_AXI_ARVALID;
  assign push    = wr_fire & (wsel == 3'd3);
  assign flush   = wr_fire & (wsel == 3'd0) & S_AXI_WDATA[1];

  assign full  = count == LW'(FIFO_DEPTH);
  assign empty = count == '0;
  // A word written on the previous edge is not yet eligible for the stage.
  assign avail = count > LW'(push_d1);
  assign load  = en & ~flush & avail & (~M_AXIS_TVALID | M_AXIS_TREADY);

  assign push_ok = push & (~full | load);
  assign ovf_set = push & full & ~load;

  assign len_eff = (pkt_len == '0) ? PKT_LEN_W'(1) : pkt_len;
  assign last    = (cnt == '0) ? (len_eff == PKT_LEN_W'(1))
                               : (cnt + PKT_LEN_W'(1) == cur_len);

  assign S_AXI_WREADY = S_AXI_AWREADY;
  assign S_AXI_BRESP  = 2'b00;
  assign S_AXI_RRESP  = 2'b00;
  assign M_AXIS_TSTRB = '1;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      en            <= 1'b0;
      pkt_len       <= PKT_LEN_W'(1);
      ovf           <= 1'b0;
    end else begin
      S_AXI_AWREADY <= S_AXI_AWVALID & S_AXI_WVALID
                     & ~S_AXI_BVALID & ~S_AXI_AWREADY;
      if (wr_fire)
        S_AXI_BVALID <= 1'b1;
      else if (S_AXI_BREADY)
        S_AXI_BVALID <= 1'b0;
      if (wr_fire && wsel == 3'd0)
        en <= S_AXI_WDATA[0];
      if (wr_fire && wsel == 3'd1)
        pkt_len <= S_AXI_WDATA[PKT_LEN_W-1:0];
      if (ovf_set)
        ovf <= 1'b1;
      else if (wr_fire && wsel == 3'd2)
        ovf <= 1'b0;
    end
  end

`ifdef TXBUF_IRQ_EN
  logic [15:0] thresh;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      thresh <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_fire && wsel == 3'd4)
        thresh <= S_AXI_WDATA[15:0];
      irq <= en & (16'(count) <= thresh) & ~flush;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    case (rsel)
      3'd0: rd_word[0] = en;
      3'd1: rd_word[PKT_LEN_W-1:0] = pkt_len;
      3'd2: begin
        rd_word[31:16] = 16'(count);
        rd_word[2:0]   = {ovf, full, empty};
      end
`ifdef TXBUF_IRQ_EN
      3'd4: rd_word[15:0] = thresh;
`endif
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_ARREADY <= S_AXI_ARVALID & ~S_AXI_RVALID & ~S_AXI_ARREADY;
      if (rd_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_word;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_ok)
      mem[wr_ptr] <= S_AXI_WDATA[TW-1:0];
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      push_d1       <= 1'b0;
      cnt           <= '0;
      cur_len       <= PKT_LEN_W'(1);
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        push_d1 <= 1'b0;
        cnt     <= '0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + AW'(1);
        if (load)
          rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !load)
          count <= count + LW'(1);
        else if (!push_ok && load)
          count <= count - LW'(1);
        push_d1 <= push_ok;
        if (load) begin
          if (cnt == '0)
            cur_len <= len_eff;
          cnt <= last ? '0 : cnt + PKT_LEN_W'(1);
        end
      end
      if (load) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= mem[rd_ptr];
        M_AXIS_TLAST  <= last;
      end else if (M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b0;
      end
    end
  end

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                    S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA};

endmodule

// File: tb/tb_tx_input_buffer_v2.sv
// Scoreboard bench for tx_input_buffer_v2: queue-based packet model,
// directed scenarios plus randomized bursts with random TREADY.
module tb_tx_input_buffer_v2;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [4:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = 4'hF;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [4:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TSTRB;
  logic        M_AXIS_TLAST;
  logic        irq;

  tx_input_buffer_v2 dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .M_AXIS_TLAST(M_AXIS_TLAST), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;

  // reference model: expected words in order, plus packet-length bookkeeping
  logic [31:0] exp_q[$];
  int m_len = 1;
  int m_cur = 1;
  int m_cnt = 0;
  int tready_mode = 0;

  logic        held = 1'b0;
  logic [31:0] held_d;
  logic        held_l;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // TREADY pattern: 0 low, 1 high, 2 toggle, other random
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      case (tready_mode)
        0: M_AXIS_TREADY = 1'b0;
        1: M_AXIS_TREADY = 1'b1;
        2: M_AXIS_TREADY = ~M_AXIS_TREADY;
        default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      held = 1'b0;
    end else begin
      if (held) begin
        tests++;
        if (!M_AXIS_TVALID || M_AXIS_TDATA !== held_d
            || M_AXIS_TLAST !== held_l) begin
          fails++;
          $display("FAIL hold_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, held_d, held_l);
        end
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat_spurious: got %h expected no beat", M_AXIS_TDATA);
        end else begin
          logic [31:0] e;
          logic        el;
          e = exp_q.pop_front();
          if (m_cnt == 0) m_cur = (m_len == 0) ? 1 : m_len;
          m_cnt++;
          el = (m_cnt == m_cur);
          if (el) m_cnt = 0;
          if (M_AXIS_TDATA !== e || M_AXIS_TLAST !== el) begin
            fails++;
            $display("FAIL beat: got d=%h l=%b expected d=%h l=%b",
                     M_AXIS_TDATA, M_AXIS_TLAST, e, el);
          end
        end
      end
      held   = M_AXIS_TVALID && !M_AXIS_TREADY;
      held_d = M_AXIS_TDATA;
      held_l = M_AXIS_TLAST;
    end
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input bit keep = 1'b1);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR  = a;
    S_AXI_WDATA   = d;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!S_AXI_AWREADY || !S_AXI_WREADY) begin
      tests++;
      fails++;
      $display("FAIL aw_timeout: got no ready expected ready for addr %h", a);
    end
    @(posedge ACLK);
    case (a)
      5'h00: if (d[1]) begin
        if (held && exp_q.size() > 0) begin
          logic [31:0] f;
          f = exp_q[0];
          exp_q.delete();
          exp_q.push_back(f);
        end else begin
          exp_q.delete();
        end
      end
      5'h04: m_len = int'(d[15:0]);
      5'h0C: if (keep) exp_q.push_back(d);
      default: ;
    endcase
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("bresp", {29'd0, S_AXI_BVALID, S_AXI_BRESP}, 32'h4);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n;
    @(negedge ACLK);
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    if (!S_AXI_RVALID || S_AXI_RRESP != 2'b00) begin
      tests++;
      fails++;
      $display("FAIL read_timeout: got rvalid=%b rresp=%0d expected 1/0 addr %h",
               S_AXI_RVALID, S_AXI_RRESP, a);
    end
    d = S_AXI_RDATA;
  endtask

  task automatic read_check(input string name, input logic [4:0] a,
                            input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || M_AXIS_TVALID) && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || M_AXIS_TVALID) begin
      fails++;
      $display("FAIL drain: got %0d words left expected 0", exp_q.size());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {M_AXIS_TVALID, M_AXIS_TLAST, S_AXI_AWREADY, S_AXI_WREADY,
                 S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, irq,
                 S_AXI_BRESP, S_AXI_RRESP}, 32'h0);
    check({name, "_tdata"}, M_AXIS_TDATA, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int n;

    // reset state
    repeat (3) @(negedge ACLK);
    check_all_zero("reset_out");
    ARESETN = 1'b1;
    read_check("reset_pktlen", 5'h04, 32'h1);
    read_check("reset_status", 5'h08, 32'h1);
    read_check("reset_ctrl", 5'h00, 32'h0);
    check("tstrb", {28'd0, M_AXIS_TSTRB}, 32'hF);

    // 8 words, 2 packets of 4
    tready_mode = 1;
    axi_write(5'h04, 32'd4);
    axi_write(5'h00, 32'h1);
    for (int i = 1; i <= 8; i++) axi_write(5'h0C, 32'(i));
    wait_drain();
    read_check("t1_status", 5'h08, 32'h1);

    // overflow with EN=0: 17th word dropped
    axi_write(5'h00, 32'h0);
    for (int i = 0; i < 17; i++)
      axi_write(5'h0C, 32'h100 + 32'(i), i < 16);
    read_check("t2_full_ovf", 5'h08, 32'h0010_0006);
    axi_write(5'h08, 32'h0);
    read_check("t2_ovf_clr", 5'h08, 32'h0010_0002);

    // drain those with PKT_LEN=3 and toggling TREADY
    axi_write(5'h04, 32'd3);
    tready_mode = 2;
    axi_write(5'h00, 32'h1);
    axi_write(5'h0C, 32'h1F0);
    axi_write(5'h0C, 32'h1F1);
    wait_drain();

    // PKT_LEN change mid-packet
    tready_mode = 0;
    axi_write(5'h04, 32'd4);
    for (int i = 1; i <= 8; i++) axi_write(5'h0C, 32'h40 + 32'(i));
    idle(4);
    tready_mode = 1;
    @(negedge ACLK);
    tready_mode = 0;
    idle(3);
    axi_write(5'h04, 32'd2);
    tready_mode = 1;
    wait_drain();

    // FLUSH with a held beat
    axi_write(5'h04, 32'd1);
    tready_mode = 0;
    for (int i = 0; i < 6; i++) axi_write(5'h0C, 32'h500 + 32'(i));
    idle(4);
    axi_write(5'h00, 32'h3);
    check("t5_held", {31'd0, M_AXIS_TVALID}, 32'h1);
    tready_mode = 1;
    wait_drain();
    idle(2);
    check("t5_idle", {31'd0, M_AXIS_TVALID}, 32'h0);
    read_check("t5_status", 5'h08, 32'h1);
    read_check("t5_ctrl", 5'h00, 32'h1);

    // unmapped words
    axi_write(5'h1C, 32'hFFFF_FFFF);
    read_check("unmapped", 5'h18, 32'h0);

`ifdef TXBUF_IRQ_EN
    axi_write(5'h10, 32'd2);
    read_check("thresh", 5'h10, 32'h2);
    tready_mode = 0;
    for (int i = 0; i < 5; i++) axi_write(5'h0C, 32'h600 + 32'(i));
    idle(3);
    check("irq_high_level", {31'd0, irq}, 32'h0);
    tready_mode = 1;
    wait_drain();
    idle(2);
    check("irq_low_level", {31'd0, irq}, 32'h1);
    axi_write(5'h00, 32'h0);
    idle(2);
    check("irq_disabled", {31'd0, irq}, 32'h0);
    axi_write(5'h00, 32'h1);
`else
    axi_write(5'h10, 32'd2);
    read_check("thresh_absent", 5'h10, 32'h0);
    check("irq_tied", {31'd0, irq}, 32'h0);
`endif

    // randomized bursts
    for (int r = 0; r < 8; r++) begin
      wait_drain();
      axi_write(5'h04, 32'($urandom_range(0, 5)));
      tready_mode = $urandom_range(1, 3);
      for (int i = 0; i < int'($urandom_range(10, 30)); i++) begin
        n = 0;
        while (exp_q.size() >= 15 && n < 500) begin
          @(negedge ACLK);
          n++;
        end
        axi_write(5'h0C, $urandom);
        if ($urandom_range(0, 9) == 0) begin
          axi_write(5'h00, 32'h0);
          idle($urandom_range(1, 6));
          axi_write(5'h00, 32'h1);
        end
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end
      wait_drain();
    end

    // reset mid-packet
    axi_write(5'h04, 32'd4);
    tready_mode = 0;
    for (int i = 0; i < 3; i++) axi_write(5'h0C, 32'h700 + 32'(i));
    idle(3);
    ARESETN = 1'b0;
    @(negedge ACLK);
    check_all_zero("t7_reset_out");
    ARESETN = 1'b1;
    exp_q.delete();
    m_len = 1;
    m_cnt = 0;
    read_check("t7_pktlen", 5'h04, 32'h1);
    read_check("t7_status", 5'h08, 32'h1);
    idle(3);
    check("t7_no_beat", {31'd0, M_AXIS_TVALID}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
